// File: rtl/reg_3r1w_rf.sv
// -----------------------------------------------------------------------------
// reg_3r1w_rf
//
// Flip-flop register file: 2^AW words of DW bits, three registered read ports
// (A, B, C) and one write port. This is the GPR storage behind the GPR wrapper.
// Port A and B addresses come from ID-stage decode, so their operands are
// valid during EXE. The write port is driven from write-back.
//
// Parameters:
//   DW      data width of every word and data port
//   AW      address width, depth = 2^AW
//   R0_ZERO 1: entry 0 reads as zero and ignores writes (RISC-V x0)
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset; clears storage and outputs
//   rd{a,b,c}_en        read enable; when low the port holds its last data
//   rd{a,b,c}_addr      read address
//   rd{a,b,c}_do        registered read data
//   wr_en               write enable
//   wr_addr, wr_data    write address and data
// -----------------------------------------------------------------------------
module reg_3r1w_rf #(
    parameter int DW      = 64,
    parameter int AW      = 5,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rda_en,
    input  logic [AW-1:0] rda_addr,
    output logic [DW-1:0] rda_do,
    input  logic          rdb_en,
    input  logic [AW-1:0] rdb_addr,
    output logic [DW-1:0] rdb_do,
    input  logic          rdc_en,
    input  logic [AW-1:0] rdc_addr,
    output logic [DW-1:0] rdc_do,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // A write to entry 0 is dropped entirely when it is hardwired to zero.
    logic          wr_eff;
    logic [DW-1:0] rda_next;
    logic [DW-1:0] rdb_next;
    logic [DW-1:0] rdc_next;

    assign wr_eff = wr_en && !(R0_ZERO && (wr_addr == '0));

    // Value a port captures for a given address: zero for a hardwired x0,
    // otherwise write-first, so a same-cycle write is seen by the read.
    function automatic logic [DW-1:0] read_word(
        input logic [AW-1:0] addr,
        input logic          w_eff,
        input logic [AW-1:0] w_addr,
        input logic [DW-1:0] w_data,
        input logic [DW-1:0] stored
    );
        logic [DW-1:0] word;
        word = stored;
        if (w_eff && (addr == w_addr)) word = w_data;
        if (R0_ZERO && (addr == '0))   word = '0;
        return word;
    endfunction

    // NOTE: every variable assigned in always_comb gets a value on every path
    // (here via the function's full assignment) so no latch is inferred.
    always_comb begin
        rda_next = read_word(rda_addr, wr_eff, wr_addr, wr_data, mem[rda_addr]);
        rdb_next = read_word(rdb_addr, wr_eff, wr_addr, wr_data, mem[rdb_addr]);
        rdc_next = read_word(rdc_addr, wr_eff, wr_addr, wr_data, mem[rdc_addr]);
    end

    // NOTE: state is updated with non-blocking assignments so that reads in
    // this edge see pre-edge storage and ordering between blocks cannot race.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array is reset word by word; this is only
            // affordable because the file is flops, not an SRAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rda_do <= '0;
            rdb_do <= '0;
            rdc_do <= '0;
        end else begin
            if (wr_eff) mem[wr_addr] <= wr_data;
            // A disabled port keeps its data so the wrapper can stall ID.
            if (rda_en) rda_do <= rda_next;
            if (rdb_en) rdb_do <= rdb_next;
            if (rdc_en) rdc_do <= rdc_next;
        end
    end

endmodule

// File: tb/tb_reg_3r1w_rf.sv
// -----------------------------------------------------------------------------
// tb_reg_3r1w_rf
//
// Scoreboarded bench for reg_3r1w_rf. Two instances share every input: one
// with R0_ZERO=1 (ports 0..2 = A,B,C) and one with R0_ZERO=0 (ports 3..5).
// Stimulus pushes the expected value of a port and the edge after which it
// must hold; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_reg_3r1w_rf;

    localparam int DW = 64;
    localparam int AW = 5;

    typedef struct {
        int          cyc;
        int          port;
        logic [DW-1:0] val;
        string       name;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          rda_en, rdb_en, rdc_en, wr_en;
    logic [AW-1:0] rda_addr, rdb_addr, rdc_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] z_a, z_b, z_c;   // R0_ZERO = 1 instance
    logic [DW-1:0] n_a, n_b, n_c;   // R0_ZERO = 0 instance

    exp_t sb_q[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    reg_3r1w_rf #(.DW(DW), .AW(AW), .R0_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rda_en(rda_en), .rda_addr(rda_addr), .rda_do(z_a),
        .rdb_en(rdb_en), .rdb_addr(rdb_addr), .rdb_do(z_b),
        .rdc_en(rdc_en), .rdc_addr(rdc_addr), .rdc_do(z_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    reg_3r1w_rf #(.DW(DW), .AW(AW), .R0_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst(rst),
        .rda_en(rda_en), .rda_addr(rda_addr), .rda_do(n_a),
        .rdb_en(rdb_en), .rdb_addr(rdb_addr), .rdb_do(n_b),
        .rdc_en(rdc_en), .rdc_addr(rdc_addr), .rdc_do(n_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [DW-1:0] port_val(input int p);
        case (p)
            0:       return z_a;
            1:       return z_b;
            2:       return z_c;
            3:       return n_a;
            4:       return n_b;
            default: return n_c;
        endcase
    endfunction

    // Monitor: compare every expectation due after the most recent edge.
    always @(negedge clk) begin
        exp_t          e;
        logic [DW-1:0] act;
        while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
            e   = sb_q.pop_front();
            act = port_val(e.port);
            checks++;
            if (e.cyc < edge_cnt) begin
                failures++;
                $display("FAIL %s port%0d: expectation for edge %0d missed (now %0d)",
                         e.name, e.port, e.cyc, edge_cnt);
            end else if (act !== e.val) begin
                failures++;
                $display("FAIL %s port%0d: got 0x%016h expected 0x%016h",
                         e.name, e.port, act, e.val);
            end
        end
    end

    // Expect port p to show v after the next rising edge.
    task automatic expect_out(input int p, input logic [DW-1:0] v, input string name);
        exp_t e;
        e.cyc  = edge_cnt + 1;
        e.port = p;
        e.val  = v;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Same expectation on both instances for ports A/B/C index p.
    task automatic expect_both(input int p, input logic [DW-1:0] v, input string name);
        expect_out(p, v, name);
        expect_out(p + 3, v, name);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        rda_en = 1'b0; rdb_en = 1'b0; rdc_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        rda_en = 1'b0; rdb_en = 1'b0; rdc_en = 1'b0; wr_en = 1'b0;
        rda_addr = '0; rdb_addr = '0; rdc_addr = '0; wr_addr = '0; wr_data = '0;
        expect_both(0, 64'h0, "reset_init");
        cycle();

        // Reset: write r5 with a bypassed read, then reset with a read pending.
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
        rda_en = 1'b1; rda_addr = 5'd5;
        expect_both(0, 64'hDEAD_BEEF_0000_0001, "pre_reset_read");
        cycle();
        rst = 1'b1; wr_en = 1'b0; rda_en = 1'b1; rda_addr = 5'd5;
        expect_both(0, 64'h0, "reset_clears_out");
        cycle();
        idle();
        rda_en = 1'b1; rda_addr = 5'd5;
        expect_both(0, 64'h0, "reset_clears_mem");
        cycle();

        // Basic write then read on all ports.
        write(5'd1, 64'h1111);
        write(5'd2, 64'h2222);
        write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        rda_en = 1'b1; rda_addr = 5'd1;
        rdb_en = 1'b1; rdb_addr = 5'd2;
        rdc_en = 1'b1; rdc_addr = 5'd31;
        expect_both(0, 64'h1111, "basic_a");
        expect_both(1, 64'h2222, "basic_b");
        expect_both(2, 64'hFFFF_FFFF_FFFF_FFFF, "basic_c");
        cycle();

        // Hold while disabled, including a write to the held address.
        idle();
        rda_en = 1'b1; rda_addr = 5'd1;
        expect_both(0, 64'h1111, "hold_setup");
        cycle();
        idle();
        rda_addr = 5'd2; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 64'h9999;
        expect_both(0, 64'h1111, "hold_1");
        cycle();
        wr_en = 1'b0;
        expect_both(0, 64'h1111, "hold_2");
        cycle();
        expect_both(0, 64'h1111, "hold_3");
        cycle();
        rda_en = 1'b1; rda_addr = 5'd1;
        expect_both(0, 64'h9999, "hold_reenable");
        cycle();

        // Write-first collision on A and B; C stays disabled and holds.
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hABCD;
        rda_en = 1'b1; rda_addr = 5'd7;
        rdb_en = 1'b1; rdb_addr = 5'd7;
        expect_both(0, 64'hABCD, "bypass_a");
        expect_both(1, 64'hABCD, "bypass_b");
        expect_both(2, 64'hFFFF_FFFF_FFFF_FFFF, "bypass_c_hold");
        cycle();

        // Entry 0: hardwired zero vs ordinary register.
        write(5'd0, 64'h1234);
        idle();
        rda_en = 1'b1; rdb_en = 1'b1; rdc_en = 1'b1;
        rda_addr = 5'd0; rdb_addr = 5'd0; rdc_addr = 5'd0;
        for (int p = 0; p < 3; p++) begin
            expect_out(p, 64'h0, "r0_zero_read");
            expect_out(p + 3, 64'h1234, "r0_plain_read");
        end
        cycle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'h5678;
        for (int p = 0; p < 3; p++) begin
            expect_out(p, 64'h0, "r0_zero_bypass");
            expect_out(p + 3, 64'h5678, "r0_plain_bypass");
        end
        cycle();

        // All three ports on the same ordinary address.
        idle();
        rda_en = 1'b1; rdb_en = 1'b1; rdc_en = 1'b1;
        rda_addr = 5'd2; rdb_addr = 5'd2; rdc_addr = 5'd2;
        for (int p = 0; p < 3; p++) expect_both(p, 64'h2222, "same_addr");
        cycle();

        // Disabled write must neither store nor bypass.
        write(5'd3, 64'h3333);
        idle();
        wr_addr = 5'd3; wr_data = 64'h5555;
        rda_en = 1'b1; rda_addr = 5'd3;
        expect_both(0, 64'h3333, "no_write_bypass");
        cycle();
        idle();
        rdb_en = 1'b1; rdb_addr = 5'd3;
        expect_both(1, 64'h3333, "no_write_store");
        cycle();

        idle();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
